// File: rtl/hazard_scoreboard_if.sv
// Datapath-side bundle for the hazard/scoreboard unit: pipeline register indices and
// controls in, stall/flush/forward selects and multi-cycle completion out.
interface hazard_scoreboard_if #(
  parameter int REG_BITS = 4
);
  localparam int NREGS = 2 ** REG_BITS;

  logic [REG_BITS-1:0] Rs1D, Rs2D;
  logic [REG_BITS-1:0] Rs1E, Rs2E, RdE;
  logic [REG_BITS-1:0] RdM, RdW;
  logic                RegWriteM, RegWriteW;
  logic                ResultSrcE, PCSrcE;
  logic                McStartD, McStartE;

  logic                StallF, StallD, FlushD, FlushE;
  logic [1:0]          ForwardAE, ForwardBE;
  logic                McDone, McBusy, McErr;
  logic [REG_BITS-1:0] McRd;
  logic [NREGS-1:0]    Busy;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McStartD, McStartE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
    input  McDone, McBusy, McErr, McRd, Busy
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, McStartD, McStartE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
    output McDone, McBusy, McErr, McRd, Busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Forwarding, load-use/scoreboard stall and branch flush for the 5-stage core, plus a
// one-deep scoreboard for the fixed-latency MUL/DIV unit. All controls are same-cycle.
module hazard_scoreboard #(
  parameter int REG_BITS = 4,
  parameter int MC_LAT   = 4,
  parameter int ZERO_REG = 1
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave hz
);
  localparam int NREGS = 2 ** REG_BITS;

  logic [3:0]          cnt;
  logic [REG_BITS-1:0] mcRdQ;
  logic [NREGS-1:0]    busyQ;
  logic [NREGS-1:0]    busyNext;
  logic                mcErrQ;

  logic accept, mcDone, mcBusy;
  logic v1D, v2D, hit1E, hit2E;
  logic lwStall, sbStall, stStall, stall;

  function automatic logic isValid(input logic [REG_BITS-1:0] r);
    return !(ZERO_REG != 0 && r == '0);
  endfunction

  function automatic logic [1:0] fwdSel(
    input logic [REG_BITS-1:0] rs,
    input logic [REG_BITS-1:0] rdM,
    input logic                wrM,
    input logic [REG_BITS-1:0] rdW,
    input logic                wrW,
    input logic [REG_BITS-1:0] mcRd,
    input logic                done
  );
    if (!isValid(rs))            return 2'b00;
    if (wrM && rs == rdM)        return 2'b10;
    if (wrW && rs == rdW)        return 2'b01;
    if (done && rs == mcRd)      return 2'b11;
    return 2'b00;
  endfunction

  assign mcDone = (cnt == 4'd1);
  assign mcBusy = (cnt != 4'd0);
  assign accept = hz.McStartE && (cnt <= 4'd1);

  // Completion clear goes first so a back-to-back issue to the same register stays busy.
  always_comb begin
    busyNext = busyQ;
    if (mcDone) busyNext[mcRdQ] = 1'b0;
    if (accept) busyNext[hz.RdE] = isValid(hz.RdE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= 4'd0;
      mcRdQ  <= '0;
      busyQ  <= '0;
      mcErrQ <= 1'b0;
    end else begin
      busyQ <= busyNext;
      if (accept) begin
        cnt   <= 4'(MC_LAT);
        mcRdQ <= hz.RdE;
      end else if (mcBusy) begin
        cnt <= cnt - 4'd1;
      end
      if (hz.McStartE && !accept) mcErrQ <= 1'b1;
    end
  end

  assign v1D   = isValid(hz.Rs1D);
  assign v2D   = isValid(hz.Rs2D);
  assign hit1E = v1D && (hz.Rs1D == hz.RdE);
  assign hit2E = v2D && (hz.Rs2D == hz.RdE);

  assign lwStall = hz.ResultSrcE && (hit1E || hit2E);
  assign sbStall = (v1D && busyQ[hz.Rs1D]) || (v2D && busyQ[hz.Rs2D])
                || (hz.McStartE && (hit1E || hit2E));
  assign stStall = hz.McStartD && (mcBusy || hz.McStartE);
  assign stall   = lwStall || sbStall || stStall;

  // A taken branch kills D anyway, so the PC must still advance to the target.
  assign hz.StallF = stall && !hz.PCSrcE;
  assign hz.StallD = stall && !hz.PCSrcE;
  assign hz.FlushD = hz.PCSrcE;
  assign hz.FlushE = stall || hz.PCSrcE;

  assign hz.ForwardAE = fwdSel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW, mcRdQ, mcDone);
  assign hz.ForwardBE = fwdSel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW, mcRdQ, mcDone);

  assign hz.McDone = mcDone;
  assign hz.McBusy = mcBusy;
  assign hz.McErr  = mcErrQ;
  assign hz.McRd   = mcRdQ;
  assign hz.Busy   = busyQ;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised plus directed bench for hazard_scoreboard; a time-based model of the
// outstanding multi-cycle op produces expected outputs, a negedge monitor compares them.
module tb_hazard_scoreboard;
  localparam int REG_BITS = 4;
  localparam int MC_LAT   = 4;

  typedef struct {
    logic       rst;
    logic [3:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       wrM, wrW, ldE, brE, mcD, mcE;
  } stim_t;

  typedef struct {
    int         cyc;
    logic       stallF, stallD, flushD, flushE;
    logic [1:0] fwdA, fwdB;
    logic       mcDone, mcBusy, mcErr;
    logic [3:0] mcRd;
    logic [15:0] busy;
  } exp_t;

  logic clk;
  logic reset;
  hazard_scoreboard_if #(.REG_BITS(REG_BITS)) hz ();

  hazard_scoreboard #(.REG_BITS(REG_BITS), .MC_LAT(MC_LAT), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycN   = 0;

  // Model: the single outstanding op is described by when it issued and where it writes.
  logic       mActive = 1'b0;
  int         mIssueT = 0;
  logic [3:0] mRd     = '0;
  logic       mErr    = 1'b0;

  function automatic logic vld(input logic [3:0] r);
    return r != 4'd0;
  endfunction

  function automatic logic [1:0] fwdExp(input stim_t s, input logic [3:0] rs, input logic done);
    if (!vld(rs)) return 2'b00;
    if (s.wrM && rs == s.rdM) return 2'b10;
    if (s.wrW && rs == s.rdW) return 2'b01;
    if (done && rs == mRd) return 2'b11;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    logic done, busyNow, acc, stall, h1, h2;
    logic [15:0] bz;
    reset         = s.rst;
    hz.Rs1D       = s.rs1D;  hz.Rs2D = s.rs2D;
    hz.Rs1E       = s.rs1E;  hz.Rs2E = s.rs2E;
    hz.RdE        = s.rdE;   hz.RdM  = s.rdM;  hz.RdW = s.rdW;
    hz.RegWriteM  = s.wrM;   hz.RegWriteW = s.wrW;
    hz.ResultSrcE = s.ldE;   hz.PCSrcE = s.brE;
    hz.McStartD   = s.mcD;   hz.McStartE = s.mcE;
    if (s.rst) begin
      mActive = 1'b0; mRd = '0; mErr = 1'b0;
    end
    // Op is outstanding for the MC_LAT cycles after issue; the last one is completion.
    busyNow = mActive && (cycN > mIssueT) && (cycN <= mIssueT + MC_LAT);
    done    = mActive && (cycN == mIssueT + MC_LAT);
    bz      = (busyNow && vld(mRd)) ? (16'd1 << mRd) : 16'd0;
    h1      = vld(s.rs1D) && s.rs1D == s.rdE;
    h2      = vld(s.rs2D) && s.rs2D == s.rdE;
    stall   = (s.ldE && (h1 || h2))
           || (vld(s.rs1D) && bz[s.rs1D]) || (vld(s.rs2D) && bz[s.rs2D])
           || (s.mcE && (h1 || h2))
           || (s.mcD && (busyNow || s.mcE));
    e.cyc    = cycN;
    e.stallF = stall && !s.brE;
    e.stallD = stall && !s.brE;
    e.flushD = s.brE;
    e.flushE = stall || s.brE;
    e.fwdA   = fwdExp(s, s.rs1E, done);
    e.fwdB   = fwdExp(s, s.rs2E, done);
    e.mcDone = done;
    e.mcBusy = busyNow;
    e.mcErr  = mErr;
    e.mcRd   = mRd;
    e.busy   = bz;
    expQ.push_back(e);
    if (!s.rst) begin
      acc = s.mcE && (!busyNow || done);
      if (acc) begin
        mActive = 1'b1; mIssueT = cycN; mRd = s.rdE;
      end else if (s.mcE) begin
        mErr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cycN++;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, rs1D: 4'd0, rs2D: 4'd0, rs1E: 4'd0, rs2E: 4'd0, rdE: 4'd0, rdM: 4'd0,
          rdW: 4'd0, wrM: 1'b0, wrW: 1'b0, ldE: 1'b0, brE: 1'b0, mcD: 1'b0, mcE: 1'b0};
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("StallF",    e.cyc, 32'(hz.StallF),    32'(e.stallF));
        chk("StallD",    e.cyc, 32'(hz.StallD),    32'(e.stallD));
        chk("FlushD",    e.cyc, 32'(hz.FlushD),    32'(e.flushD));
        chk("FlushE",    e.cyc, 32'(hz.FlushE),    32'(e.flushE));
        chk("ForwardAE", e.cyc, 32'(hz.ForwardAE), 32'(e.fwdA));
        chk("ForwardBE", e.cyc, 32'(hz.ForwardBE), 32'(e.fwdB));
        chk("McDone",    e.cyc, 32'(hz.McDone),    32'(e.mcDone));
        chk("McBusy",    e.cyc, 32'(hz.McBusy),    32'(e.mcBusy));
        chk("McErr",     e.cyc, 32'(hz.McErr),     32'(e.mcErr));
        chk("McRd",      e.cyc, 32'(hz.McRd),      32'(e.mcRd));
        chk("Busy",      e.cyc, 32'(hz.Busy),      32'(e.busy));
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    reset = 1'b1;
    s = idle();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE = 1'b0; hz.PCSrcE = 1'b0;
    hz.McStartD = 1'b0; hz.McStartE = 1'b0;
    @(posedge clk);
    #1;

    s = idle(); s.rst = 1'b1; step(s); step(s);
    s = idle(); step(s);

    // Forward priority and the hardwired zero register.
    s = idle(); s.rs1E = 4'd3; s.rdM = 4'd3; s.rdW = 4'd3; s.wrM = 1'b1; s.wrW = 1'b1; step(s);
    s.wrM = 1'b0; step(s);
    s = idle(); s.wrM = 1'b1; s.wrW = 1'b1; step(s);

    // Load-use, then the same hazard under a taken branch.
    s = idle(); s.ldE = 1'b1; s.rdE = 4'd5; s.rs2D = 4'd5; step(s);
    s.brE = 1'b1; step(s);

    // MC op to r7 with a D-stage consumer, forwarded in the completion cycle.
    s = idle(); s.mcE = 1'b1; s.rdE = 4'd7; s.rs1D = 4'd7; step(s);
    for (int i = 1; i <= 5; i++) begin
      s = idle(); s.rs1D = 4'd7;
      if (i == 4) s.rs1E = 4'd7;
      step(s);
    end

    // Structural stall, back-to-back issue at completion, then an illegal issue and reset.
    s = idle(); s.mcE = 1'b1; s.rdE = 4'd2; step(s);
    for (int i = 1; i <= 3; i++) begin
      s = idle(); s.mcD = 1'b1; step(s);
    end
    s = idle(); s.mcE = 1'b1; s.rdE = 4'd2; s.rs1E = 4'd2; step(s);
    s = idle(); step(s);
    s = idle(); s.mcE = 1'b1; s.rdE = 4'd9; step(s);
    s = idle(); s.rs2D = 4'd2; step(s);
    s = idle(); s.rst = 1'b1; s.rs2D = 4'd2; step(s);
    s = idle(); s.rs2D = 4'd2; step(s);

    for (int n = 0; n < 1500; n++) begin
      s.rst  = ($urandom_range(0, 149) == 0);
      s.rs1D = 4'($urandom_range(0, 7));
      s.rs2D = 4'($urandom_range(0, 7));
      s.rs1E = 4'($urandom_range(0, 7));
      s.rs2E = 4'($urandom_range(0, 7));
      s.rdE  = 4'($urandom_range(0, 7));
      s.rdM  = 4'($urandom_range(0, 7));
      s.rdW  = 4'($urandom_range(0, 7));
      s.wrM  = 1'($urandom_range(0, 1));
      s.wrW  = 1'($urandom_range(0, 1));
      s.ldE  = ($urandom_range(0, 3) == 0);
      s.brE  = ($urandom_range(0, 7) == 0);
      s.mcD  = ($urandom_range(0, 5) == 0);
      s.mcE  = ($urandom_range(0, 4) == 0);
      step(s);
    end

    @(negedge clk);
    #1;
    chk("drain", cycN, 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
